// File: rtl/reorder_buffer_pkg.sv
// Shared reorder buffer definitions: entry count, tag width, destination
// encodings and the tag-advance helper used for head/tail pointers.
package reorder_buffer_pkg;

  localparam int unsigned DEFAULT_ROB_SIZE = 15;
  localparam int unsigned TAG_W            = 4;
  localparam int unsigned NUM_SLOTS        = 1 << TAG_W;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned RD_W             = 5;
  localparam int unsigned DEST_W           = 2;

  typedef enum logic [DEST_W-1:0] {
    DEST_MEM    = 2'd0,
    DEST_REG    = 2'd1,
    DEST_BRANCH = 2'd2,
    DEST_JL     = 2'd3
  } dest_type_e;

  // Tags run 1..size; tag 0 is reserved for "no producer", so wrap to 1.
  function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] tag,
                                                input int unsigned       size);
    logic [TAG_W-1:0] nxt;
    if (tag == TAG_W'(size)) nxt = TAG_W'(1);
    else                     nxt = tag + TAG_W'(1);
    return nxt;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates tags at issue, collects CDB writebacks,
// forwards operand values to the issue stage and retires entries in order.
// A mispredicted branch at retirement raises a one-cycle flush and empties
// the buffer.
//
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global stall when low)
//   issue_*        : allocation request; issue_tag is the tag it will get
//   rob_full/empty : occupancy flags (combinational)
//   query_*        : two operand lookups (combinational)
//   wb_*           : CDB writeback, with branch outcome
//   commit_*       : registered in-order retirement pulse
//   flush_out/pc   : registered flush request and redirect PC
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_SIZE = DEFAULT_ROB_SIZE
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,

  input  logic              issue_valid,
  input  logic [1:0]        issue_dest_type,
  input  logic [4:0]        issue_rd,
  input  logic [31:0]       issue_pc,
  output logic [3:0]        issue_tag,
  output logic              rob_full,
  output logic              rob_empty,

  input  logic [3:0]        query_tag1,
  input  logic [3:0]        query_tag2,
  output logic              query_ready1,
  output logic              query_ready2,
  output logic [31:0]       query_value1,
  output logic [31:0]       query_value2,

  input  logic              wb_valid,
  input  logic [3:0]        wb_tag,
  input  logic [31:0]       wb_value,
  input  logic              wb_mispredict,
  input  logic [31:0]       wb_target,

  output logic              commit_valid,
  output logic [3:0]        commit_tag,
  output logic [4:0]        commit_rd,
  output logic [31:0]       commit_value,
  output logic [1:0]        commit_dest_type,

  output logic              flush_out,
  output logic [31:0]       flush_pc
);

  localparam int unsigned CNT_W = $clog2(ROB_SIZE + 1);

  // Per-field entry storage indexed directly by tag; slot 0 is never busy.
  logic              ent_busy     [NUM_SLOTS];
  logic              ent_ready    [NUM_SLOTS];
  dest_type_e        ent_dest     [NUM_SLOTS];
  logic [RD_W-1:0]   ent_rd       [NUM_SLOTS];
  logic [DATA_W-1:0] ent_value    [NUM_SLOTS];
  logic              ent_mispred  [NUM_SLOTS];
  logic [DATA_W-1:0] ent_target   [NUM_SLOTS];

  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              do_commit;
  logic              do_flush;
  logic              issue_acc;
  logic              wb_hit;

  // The instruction PC is not needed at retirement: redirect targets arrive
  // with the branch writeback.
  logic unused_issue_pc;
  assign unused_issue_pc = ^issue_pc;

  // Occupancy and next-tag status.
  assign issue_tag = tail;
  assign rob_full  = (count == CNT_W'(ROB_SIZE));
  assign rob_empty = (count == CNT_W'(0));

  // Operand lookup: tag 0 is a constant, stored results win, then the CDB.
  function automatic logic [DATA_W:0] lookup(input logic [TAG_W-1:0] tag);
    logic [DATA_W:0] res;
    res = {1'b0, DATA_W'(0)};
    if (tag == TAG_W'(0))                  res = {1'b1, DATA_W'(0)};
    else if (ent_busy[tag] && ent_ready[tag]) res = {1'b1, ent_value[tag]};
    else if (wb_valid && (wb_tag == tag))  res = {1'b1, wb_value};
    return res;
  endfunction

  always_comb begin
    {query_ready1, query_value1} = lookup(query_tag1);
    {query_ready2, query_value2} = lookup(query_tag2);
  end

  // Per-cycle control decisions, all taken from pre-edge state.
  always_comb begin
    do_commit = ent_busy[head] && ent_ready[head];
    do_flush  = do_commit && (ent_dest[head] == DEST_BRANCH) && ent_mispred[head];
    issue_acc = issue_valid && !rob_full && !flush_out;
    wb_hit    = wb_valid && (wb_tag != TAG_W'(0)) && ent_busy[wb_tag];
  end

  // Entry state, pointers and registered retirement/flush outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        ent_busy[i]  <= 1'b0;
        ent_ready[i] <= 1'b0;
      end
      head             <= TAG_W'(1);
      tail             <= TAG_W'(1);
      count            <= CNT_W'(0);
      commit_valid     <= 1'b0;
      commit_tag       <= '0;
      commit_rd        <= '0;
      commit_value     <= '0;
      commit_dest_type <= '0;
      flush_out        <= 1'b0;
      flush_pc         <= '0;
    end else if (rdy_in) begin
      commit_valid <= do_commit;
      flush_out    <= do_flush;

      if (do_commit) begin
        commit_tag       <= head;
        commit_rd        <= (ent_dest[head] == DEST_MEM) ? RD_W'(0) : ent_rd[head];
        commit_value     <= ent_value[head];
        commit_dest_type <= ent_dest[head];
      end

      if (do_flush) begin
        // Squash everything younger, including anything arriving this edge.
        flush_pc <= ent_target[head];
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
          ent_busy[i]  <= 1'b0;
          ent_ready[i] <= 1'b0;
        end
        head  <= TAG_W'(1);
        tail  <= TAG_W'(1);
        count <= CNT_W'(0);
      end else begin
        if (wb_hit) begin
          ent_ready[wb_tag] <= 1'b1;
          ent_value[wb_tag] <= wb_value;
          if (ent_dest[wb_tag] == DEST_BRANCH) begin
            ent_mispred[wb_tag] <= wb_mispredict;
            ent_target[wb_tag]  <= wb_target;
          end
        end

        if (do_commit) begin
          ent_busy[head]  <= 1'b0;
          ent_ready[head] <= 1'b0;
          head            <= next_tag(head, ROB_SIZE);
        end

        if (issue_acc) begin
          ent_busy[tail]    <= 1'b1;
          ent_ready[tail]   <= 1'b0;
          ent_dest[tail]    <= dest_type_e'(issue_dest_type);
          ent_rd[tail]      <= issue_rd;
          ent_mispred[tail] <= 1'b0;
          tail              <= next_tag(tail, ROB_SIZE);
        end

        case ({issue_acc, do_commit})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: issues push expected retirements,
// a negedge monitor pops and compares every commit.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        issue_valid = 1'b0;
  logic [1:0]  issue_dest_type = '0;
  logic [4:0]  issue_rd = '0;
  logic [31:0] issue_pc = '0;
  logic [3:0]  issue_tag;
  logic        rob_full, rob_empty;
  logic [3:0]  query_tag1 = '0, query_tag2 = '0;
  logic        query_ready1, query_ready2;
  logic [31:0] query_value1, query_value2;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_tag = '0;
  logic [31:0] wb_value = '0;
  logic        wb_mispredict = 1'b0;
  logic [31:0] wb_target = '0;
  logic        commit_valid;
  logic [3:0]  commit_tag;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [1:0]  commit_dest_type;
  logic        flush_out;
  logic [31:0] flush_pc;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_dest_type(issue_dest_type),
    .issue_rd(issue_rd), .issue_pc(issue_pc), .issue_tag(issue_tag),
    .rob_full(rob_full), .rob_empty(rob_empty),
    .query_tag1(query_tag1), .query_tag2(query_tag2),
    .query_ready1(query_ready1), .query_ready2(query_ready2),
    .query_value1(query_value1), .query_value2(query_value2),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .wb_mispredict(wb_mispredict), .wb_target(wb_target),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_dest_type(commit_dest_type),
    .flush_out(flush_out), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [3:0]  tag;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [1:0]  dt;
    logic        flush;
    logic [31:0] fpc;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [3:0]  exp_tail = 4'd1;
  logic [31:0] tb_val [16];
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Commit monitor.
  always @(negedge clk_in) begin : mon
    exp_t e;
    if (mon_en && !rst_in) begin
      if (commit_valid) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_commit: got tag %0d expected none at %0t", commit_tag, $time);
        end else begin
          e = sb.pop_front();
          chk("commit_tag",   32'(commit_tag),       32'(e.tag));
          chk("commit_rd",    32'(commit_rd),        32'(e.rd));
          chk("commit_value", commit_value,          e.val);
          chk("commit_dest",  32'(commit_dest_type), 32'(e.dt));
          chk("commit_flush", 32'(flush_out),        32'(e.flush));
          if (e.flush) chk("flush_pc", flush_pc, e.fpc);
        end
      end else if (flush_out) begin
        chk("flush_without_commit", 32'(flush_out), 32'd0);
      end
    end
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset;
    chk("scoreboard_empty_before_reset", 32'(sb.size()), 32'd0);
    sb.delete();
    rst_in = 1'b1; rdy_in = 1'b0; issue_valid = 1'b1; wb_valid = 1'b1; wb_tag = 4'd1;
    tick;
    tick;
    rst_in = 1'b0; rdy_in = 1'b1; issue_valid = 1'b0; wb_valid = 1'b0;
    exp_tail = 4'd1;
    mon_en = 1'b1;
    chk("rst_empty",        32'(rob_empty),    32'd1);
    chk("rst_full",         32'(rob_full),     32'd0);
    chk("rst_issue_tag",    32'(issue_tag),    32'd1);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_flush",        32'(flush_out),    32'd0);
    chk("rst_commit_value", commit_value,      32'd0);
    chk("rst_flush_pc",     flush_pc,          32'd0);
  endtask

  task automatic issue(input logic [1:0] dt, input logic [4:0] rd, input logic [31:0] val,
                       input bit exp_commit, input bit mis, input logic [31:0] tgt);
    exp_t e;
    chk("issue_tag", 32'(issue_tag), 32'(exp_tail));
    issue_valid = 1'b1; issue_dest_type = dt; issue_rd = rd; issue_pc = {exp_tail, 2'b00};
    tick;
    issue_valid = 1'b0;
    e.tag = exp_tail; e.rd = (dt == DEST_MEM) ? 5'd0 : rd; e.val = val; e.dt = dt;
    e.flush = mis; e.fpc = tgt;
    if (exp_commit) sb.push_back(e);
    tb_val[exp_tail] = val;
    exp_tail = (exp_tail == 4'd15) ? 4'd1 : exp_tail + 4'd1;
  endtask

  task automatic wb(input logic [3:0] tag, input logic [31:0] val, input bit mis,
                    input logic [31:0] tgt);
    wb_valid = 1'b1; wb_tag = tag; wb_value = val; wb_mispredict = mis; wb_target = tgt;
    tick;
    wb_valid = 1'b0; wb_mispredict = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      tick;
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tick;
    // Fill, over-issue while full, wrap the tags, out-of-order writebacks.
    do_reset;
    for (int t = 1; t <= 15; t++) issue(DEST_REG, 5'(t), 32'h100 + 32'(t), 1, 0, 0);
    chk("full_after_15", 32'(rob_full), 32'd1);
    chk("tag_after_15",  32'(issue_tag), 32'd1);
    issue_valid = 1'b1; issue_dest_type = DEST_REG; issue_rd = 5'd9;
    tick;
    chk("issue_when_full_tag", 32'(issue_tag), 32'd1);
    chk("issue_when_full_flag", 32'(rob_full), 32'd1);
    wb_valid = 1'b1; wb_tag = 4'd1; wb_value = tb_val[1];
    tick;
    wb_valid = 1'b0;
    tick;                                   // tag 1 commits; issue still refused
    issue_valid = 1'b0;
    chk("issue_at_full_commit_tag", 32'(issue_tag), 32'd1);
    chk("full_after_one_commit", 32'(rob_full), 32'd0);
    wb(4'd2, tb_val[2], 0, 0);
    issue(DEST_REG, 5'd1, 32'h201, 1, 0, 0); // same edge as commit of tag 2
    issue(DEST_REG, 5'd2, 32'h202, 1, 0, 0);
    chk("full_after_reuse", 32'(rob_full), 32'd1);
    wb(4'd2, tb_val[2], 0, 0);
    wb(4'd1, tb_val[1], 0, 0);
    for (int t = 15; t >= 3; t--) wb(4'(t), tb_val[t], 0, 0);
    drain(40);

    // In-order retirement with no writeback-to-commit bypass.
    do_reset;
    issue(DEST_REG, 5'd4, 32'h11, 1, 0, 0);
    issue(DEST_REG, 5'd5, 32'h22, 1, 0, 0);
    wb(4'd2, 32'h22, 0, 0);
    wb(4'd1, 32'h11, 0, 0);
    chk("no_bypass", 32'(commit_valid), 32'd0);
    tick;
    chk("commit1_valid", 32'(commit_valid), 32'd1);
    chk("commit1_tag",   32'(commit_tag),   32'd1);
    tick;
    chk("commit2_valid", 32'(commit_valid), 32'd1);
    chk("commit2_tag",   32'(commit_tag),   32'd2);
    drain(5);

    // Operand forwarding.
    do_reset;
    issue(DEST_REG, 5'd1, 32'h31, 1, 0, 0);
    issue(DEST_REG, 5'd2, 32'h32, 1, 0, 0);
    issue(DEST_REG, 5'd3, 32'hDEAD, 1, 0, 0);
    query_tag1 = 4'd2; query_tag2 = 4'd0;
    #1;
    chk("query_pending_ready", 32'(query_ready1), 32'd0);
    chk("query_tag0_ready",    32'(query_ready2), 32'd1);
    chk("query_tag0_value",    query_value2,      32'd0);
    wb_valid = 1'b1; wb_tag = 4'd3; wb_value = 32'hDEAD; query_tag1 = 4'd3;
    #1;
    chk("query_cdb_ready", 32'(query_ready1), 32'd1);
    chk("query_cdb_value", query_value1,      32'hDEAD);
    tick;
    wb_valid = 1'b0;
    #1;
    chk("query_stored_ready", 32'(query_ready1), 32'd1);
    chk("query_stored_value", query_value1,      32'hDEAD);
    wb(4'd1, 32'h31, 0, 0);
    wb(4'd2, 32'h32, 0, 0);
    drain(10);

    // Mispredicted branch flushes everything younger.
    do_reset;
    issue(DEST_BRANCH, 5'd0, 32'h55, 1, 1, 32'h100);
    issue(DEST_REG, 5'd2, 32'h2, 0, 0, 0);
    issue(DEST_REG, 5'd3, 32'h3, 0, 0, 0);
    wb(4'd1, 32'h55, 1, 32'h100);
    issue_valid = 1'b1; issue_dest_type = DEST_REG; issue_rd = 5'd4;
    wb_valid = 1'b1; wb_tag = 4'd2; wb_value = 32'h99;
    tick;                                   // flush edge
    wb_valid = 1'b0;
    exp_tail = 4'd1;
    chk("flush_out", 32'(flush_out), 32'd1);
    chk("flush_pc_now", flush_pc, 32'h100);
    chk("flush_empty", 32'(rob_empty), 32'd1);
    chk("flush_issue_tag", 32'(issue_tag), 32'd1);
    tick;                                   // issue during flush_out is refused
    issue_valid = 1'b0;
    chk("issue_during_flush", 32'(issue_tag), 32'd1);
    chk("empty_after_flush", 32'(rob_empty), 32'd1);
    query_tag1 = 4'd2;
    #1;
    chk("flushed_entry_not_ready", 32'(query_ready1), 32'd0);
    issue(DEST_REG, 5'd6, 32'h66, 1, 0, 0);
    wb(4'd1, 32'h66, 0, 0);
    drain(5);

    // Stall holds a ready head; mem/jl retirement fields.
    do_reset;
    issue(DEST_MEM, 5'd7, 32'h44, 1, 0, 0);
    issue(DEST_JL, 5'd31, 32'h1004, 1, 0, 0);
    wb(4'd2, 32'h1004, 0, 0);
    wb(4'd1, 32'h44, 0, 0);
    rdy_in = 1'b0; issue_valid = 1'b1; issue_dest_type = DEST_REG;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_no_commit", 32'(commit_valid), 32'd0);
      chk("stall_tag_hold",  32'(issue_tag),    32'd3);
    end
    rdy_in = 1'b1; issue_valid = 1'b0;
    tick;
    chk("resume_commit_valid", 32'(commit_valid), 32'd1);
    chk("resume_commit_tag",   32'(commit_tag),   32'd1);
    drain(10);

    tick;
    chk("scoreboard_empty_at_end", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
